// File: rtl/vic_pkg.sv
// Shared sizing and FSM encoding for the vectored interrupt controller.
package vic_pkg;
    localparam int NUM_IRQ = 31;
    localparam int IDX_W   = 5;
    localparam int VEC_W   = 32;

    // Write index that selects the default (spurious) vector register.
    localparam logic [IDX_W-1:0] DEF_IDX = 5'd31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } vic_state_e;
endpackage

// File: rtl/vic_prio_enc.sv
// Lowest-set-bit priority encoder; lower index wins.
module vic_prio_enc #(
    parameter int WIDTH = 31,
    parameter int OUT_W = 5
) (
    input  logic [WIDTH-1:0] req,
    output logic [OUT_W-1:0] idx,
    output logic             vld
);
    // Scan downward so the last hit, the lowest set bit, is the one kept.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = OUT_W'(i);
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vic_vector_ctrl.sv
// Vector controller: pending/in-service tracking, CPU request FSM and vector table.
module vic_vector_ctrl #(
    parameter int NUM_IRQ = vic_pkg::NUM_IRQ,
    parameter int VEC_W   = vic_pkg::VEC_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_irq_stb,
    input  logic [vic_pkg::IDX_W-1:0] i_irq_addr,
    input  logic                      i_wr_en,
    input  logic [vic_pkg::IDX_W-1:0] i_wr_idx,
    input  logic [VEC_W-1:0]          i_wr_data,
    input  logic                      i_cpu_ack,
    input  logic                      i_cpu_eoi,
    output logic                      o_cpu_irq,
    output logic [VEC_W-1:0]          o_vector,
    output logic                      o_vector_vld,
    output logic                      o_busy,
    output logic                      o_spurious
);
    import vic_pkg::*;

    vic_state_e         state, state_nxt;
    logic [NUM_IRQ-1:0] pending, pending_nxt;
    logic [NUM_IRQ-1:0] in_service, in_service_nxt;
    logic [VEC_W-1:0]   vec_tbl [NUM_IRQ];
    logic [VEC_W-1:0]   def_vec;
    logic [IDX_W-1:0]   p_idx, c_idx;
    logic               p_vld, c_vld, eligible;
    logic               cpu_irq, ack_req, ack_idle, eoi_spur;

    vic_prio_enc #(.WIDTH(NUM_IRQ), .OUT_W(IDX_W)) u_pend_enc (
        .req(pending), .idx(p_idx), .vld(p_vld)
    );

    vic_prio_enc #(.WIDTH(NUM_IRQ), .OUT_W(IDX_W)) u_serv_enc (
        .req(in_service), .idx(c_idx), .vld(c_vld)
    );

    // Only strict preemption: an equal-priority re-request waits for its EOI.
    assign eligible = p_vld && i_en && (!c_vld || (p_idx < c_idx));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (eligible) state_nxt = ST_REQ;
            ST_REQ:  if (i_cpu_ack || !eligible) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_irq  = (state == ST_REQ);
        ack_req  = cpu_irq && i_cpu_ack;
        ack_idle = !cpu_irq && i_cpu_ack;
        eoi_spur = i_cpu_eoi && !c_vld;
    end

    assign o_cpu_irq = cpu_irq;

    // Ordering matters: EOI clears before ack sets, and a strobe sets after ack clears.
    always_comb begin
        pending_nxt    = pending;
        in_service_nxt = in_service;
        if (ack_req) pending_nxt[p_idx] = 1'b0;
        if (i_irq_stb && (int'(i_irq_addr) < NUM_IRQ)) pending_nxt[i_irq_addr] = 1'b1;
        if (i_cpu_eoi && c_vld) in_service_nxt[c_idx] = 1'b0;
        if (ack_req) in_service_nxt[p_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NUM_IRQ; i++) vec_tbl[i] <= '0;
            def_vec <= '0;
        end else if (i_wr_en) begin
            if (i_wr_idx == DEF_IDX)             def_vec <= i_wr_data;
            else if (int'(i_wr_idx) < NUM_IRQ) vec_tbl[i_wr_idx] <= i_wr_data;
        end
    end

    // Table reads see the pre-write value when a write hits the acked entry.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_vector     <= '0;
            o_vector_vld <= 1'b0;
            o_spurious   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            if (ack_req)       o_vector <= vec_tbl[p_idx];
            else if (ack_idle) o_vector <= def_vec;
            o_vector_vld <= ack_req || ack_idle;
            o_spurious   <= ack_idle || eoi_spur;
            o_busy       <= |in_service_nxt;
        end
    end
endmodule

// File: tb/tb_vic_vector_ctrl.sv
// Directed self-checking bench for vic_vector_ctrl.
module tb_vic_vector_ctrl;
    logic        clk, rst, en, irq_stb, wr_en, cpu_ack, cpu_eoi;
    logic [4:0]  irq_addr, wr_idx;
    logic [31:0] wr_data;
    logic        cpu_irq, vector_vld, busy, spurious;
    logic [31:0] vector;
    int errs = 0;
    int checks = 0;

    vic_vector_ctrl #(.NUM_IRQ(31), .VEC_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_irq_stb(irq_stb), .i_irq_addr(irq_addr),
        .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
        .i_cpu_ack(cpu_ack), .i_cpu_eoi(cpu_eoi),
        .o_cpu_irq(cpu_irq), .o_vector(vector), .o_vector_vld(vector_vld),
        .o_busy(busy), .o_spurious(spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [4:0] idx);
        irq_stb = 1'b1; irq_addr = idx;
        tick();
        irq_stb = 1'b0;
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic eoi();
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        wr_en = 1'b1; wr_idx = idx; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++; if (cpu_irq !== 1'b0) begin errs++; $display("FAIL rst_irq: got %0b want 0", cpu_irq); end
        checks++; if (vector !== 32'h0) begin errs++; $display("FAIL rst_vector: got %h want 0", vector); end
        checks++; if ({vector_vld, busy, spurious} !== 3'b000) begin errs++; $display("FAIL rst_flags: got %b want 000", {vector_vld, busy, spurious}); end
        rst = 1'b1;
        tick();
        wr(5'd3, 32'h1000_0030);
        wr(5'd7, 32'h1000_0070);
        wr(5'd9, 32'h1000_0090);
        wr(5'd31, 32'hFFFF_0000);
    endtask

    task automatic test_basic();
        strobe(5'd7);
        checks++; if (cpu_irq !== 1'b0) begin errs++; $display("FAIL basic_irq_early: got %0b want 0", cpu_irq); end
        tick();
        checks++; if (cpu_irq !== 1'b1) begin errs++; $display("FAIL basic_irq: got %0b want 1", cpu_irq); end
        ack();
        checks++; if (vector !== 32'h1000_0070) begin errs++; $display("FAIL basic_vector: got %h want 10000070", vector); end
        checks++; if ({vector_vld, busy, cpu_irq} !== 3'b110) begin errs++; $display("FAIL basic_flags: got %b want 110", {vector_vld, busy, cpu_irq}); end
        tick();
        checks++; if (vector_vld !== 1'b0) begin errs++; $display("FAIL basic_vld_pulse: got %0b want 0", vector_vld); end
    endtask

    task automatic test_preempt();
        strobe(5'd9);
        tick(); tick();
        checks++; if (cpu_irq !== 1'b0) begin errs++; $display("FAIL pre_lower_blocked: got %0b want 0", cpu_irq); end
        strobe(5'd3);
        tick();
        checks++; if (cpu_irq !== 1'b1) begin errs++; $display("FAIL pre_higher_irq: got %0b want 1", cpu_irq); end
        ack();
        checks++; if (vector !== 32'h1000_0030) begin errs++; $display("FAIL pre_vector: got %h want 10000030", vector); end
        eoi();
        tick();
        checks++; if ({busy, cpu_irq} !== 2'b10) begin errs++; $display("FAIL pre_after_eoi1: got %b want 10", {busy, cpu_irq}); end
        eoi();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL pre_busy_clear: got %0b want 0", busy); end
        tick();
        checks++; if (cpu_irq !== 1'b1) begin errs++; $display("FAIL pre_irq9_after_eoi: got %0b want 1", cpu_irq); end
        ack();
        checks++; if (vector !== 32'h1000_0090) begin errs++; $display("FAIL pre_vector9: got %h want 10000090", vector); end
        eoi();
    endtask

    task automatic test_nested();
        strobe(5'd3);
        strobe(5'd9);
        ack();
        checks++; if (vector !== 32'h1000_0030) begin errs++; $display("FAIL nest_vec3: got %h want 10000030", vector); end
        eoi();
        tick();
        ack();
        checks++; if (vector !== 32'h1000_0090) begin errs++; $display("FAIL nest_vec9: got %h want 10000090", vector); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL nest_busy: got %0b want 1", busy); end
        eoi();
        checks++; if ({busy, spurious} !== 2'b00) begin errs++; $display("FAIL nest_eoi1: got %b want 00", {busy, spurious}); end
        eoi();
        checks++; if ({busy, spurious} !== 2'b01) begin errs++; $display("FAIL nest_eoi2: got %b want 01", {busy, spurious}); end
    endtask

    task automatic test_spurious();
        strobe(5'd31);
        tick(); tick();
        checks++; if (cpu_irq !== 1'b0) begin errs++; $display("FAIL spur_out_of_range: got %0b want 0", cpu_irq); end
        ack();
        checks++; if (vector !== 32'hFFFF_0000) begin errs++; $display("FAIL spur_default_vec: got %h want ffff0000", vector); end
        checks++; if ({vector_vld, spurious, busy} !== 3'b110) begin errs++; $display("FAIL spur_ack_flags: got %b want 110", {vector_vld, spurious, busy}); end
        tick();
        checks++; if ({vector_vld, spurious} !== 2'b00) begin errs++; $display("FAIL spur_pulse: got %b want 00", {vector_vld, spurious}); end
        eoi();
        checks++; if ({vector_vld, spurious} !== 2'b01) begin errs++; $display("FAIL spur_eoi: got %b want 01", {vector_vld, spurious}); end
    endtask

    task automatic test_corners();
        wr(5'd5, 32'h0000_0055);
        strobe(5'd5);
        tick();
        // ack, same-index strobe and same-index table write all land together
        cpu_ack = 1'b1; irq_stb = 1'b1; irq_addr = 5'd5;
        wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'h0000_00AA;
        tick();
        cpu_ack = 1'b0; irq_stb = 1'b0; wr_en = 1'b0;
        checks++; if (vector !== 32'h0000_0055) begin errs++; $display("FAIL corner_prewrite: got %h want 00000055", vector); end
        tick();
        checks++; if (cpu_irq !== 1'b0) begin errs++; $display("FAIL corner_no_self_preempt: got %0b want 0", cpu_irq); end
        eoi();
        tick();
        checks++; if (cpu_irq !== 1'b1) begin errs++; $display("FAIL corner_rerequest_kept: got %0b want 1", cpu_irq); end
        ack();
        checks++; if (vector !== 32'h0000_00AA) begin errs++; $display("FAIL corner_newval: got %h want 000000aa", vector); end
        eoi();
        strobe(5'd9);
        tick();
        ack();
        strobe(5'd3);
        tick();
        cpu_ack = 1'b1; cpu_eoi = 1'b1;
        tick();
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
        checks++; if ({vector, busy, spurious} !== {32'h1000_0030, 2'b10}) begin errs++; $display("FAIL corner_ack_eoi: got %h/%b want 10000030/10", vector, {busy, spurious}); end
        strobe(5'd5);
        tick(); tick();
        checks++; if (cpu_irq !== 1'b0) begin errs++; $display("FAIL corner_eoi_order: got %0b want 0", cpu_irq); end
        eoi();
        tick();
        ack();
        checks++; if (vector !== 32'h0000_00AA) begin errs++; $display("FAIL corner_vec5: got %h want 000000aa", vector); end
        eoi();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL corner_idle: got %0b want 0", busy); end
    endtask

    task automatic test_enable_reset();
        strobe(5'd3);
        tick();
        checks++; if (cpu_irq !== 1'b1) begin errs++; $display("FAIL en_irq: got %0b want 1", cpu_irq); end
        en = 1'b0;
        tick();
        checks++; if (cpu_irq !== 1'b0) begin errs++; $display("FAIL en_withdraw: got %0b want 0", cpu_irq); end
        tick();
        en = 1'b1;
        tick();
        checks++; if (cpu_irq !== 1'b1) begin errs++; $display("FAIL en_pending_kept: got %0b want 1", cpu_irq); end
        rst = 1'b0;
        #2;
        checks++; if ({cpu_irq, vector_vld, busy, spurious} !== 4'b0000) begin errs++; $display("FAIL rst_async_flags: got %b want 0000", {cpu_irq, vector_vld, busy, spurious}); end
        checks++; if (vector !== 32'h0) begin errs++; $display("FAIL rst_async_vector: got %h want 0", vector); end
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if ({cpu_irq, vector_vld} !== 2'b00) begin errs++; $display("FAIL rst_discard: got %b want 00", {cpu_irq, vector_vld}); end
        ack();
        checks++; if ({vector, spurious} !== {32'h0, 1'b1}) begin errs++; $display("FAIL rst_default_cleared: got %h/%0b want 0/1", vector, spurious); end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; irq_stb = 1'b0; irq_addr = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
        test_reset();
        test_basic();
        test_preempt();
        test_nested();
        test_spurious();
        test_corners();
        test_enable_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/vic_vector_ctrl.md
VIC_VECTOR_CTRL -- requirements
Module: vic_vector_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 31, number of interrupt sources.
REQ-002 SHALL have parameter VEC_W, default 32, vector address width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port i_en, input, 1, global enable for CPU requests.
REQ-006 SHALL have port i_irq_stb, input, 1, one-cycle request strobe from vic_irq.
REQ-007 SHALL have port i_irq_addr, input, 5, source index qualified by i_irq_stb.
REQ-008 SHALL have port i_wr_en, input, 1, vector table write strobe.
REQ-009 SHALL have port i_wr_idx, input, 5, table entry written; index 31 selects the default vector.
REQ-010 SHALL have port i_wr_data, input, VEC_W, vector value written.
REQ-011 SHALL have port i_cpu_ack, input, 1, CPU vector-read acknowledge.
REQ-012 SHALL have port i_cpu_eoi, input, 1, CPU end-of-interrupt strobe.
REQ-013 SHALL have port o_cpu_irq, output, 1, registered request level to the CPU.
REQ-014 SHALL have port o_vector, output, VEC_W, registered vector address.
REQ-015 SHALL have port o_vector_vld, output, 1, one-cycle pulse marking o_vector valid.
REQ-016 SHALL have port o_busy, output, 1, high while any source is in service; this is the completion level fed back to vic_irq.
REQ-017 SHALL have port o_spurious, output, 1, one-cycle pulse on an ack or EOI with nothing to act on.

Function
REQ-018 SHALL hold pending[NUM_IRQ-1:0]: i_irq_stb sets pending[i_irq_addr]; an out-of-range index (>=NUM_IRQ) is ignored.
REQ-019 SHALL hold in_service[NUM_IRQ-1:0]; lower index means higher priority.
REQ-020 SHALL compute p = lowest set pending index and c = lowest set in_service index (c = NUM_IRQ when none).
REQ-021 SHALL treat a request as eligible when pending != 0, i_en = 1 and p < c (strict preemption only).
REQ-022 SHALL implement an FSM with states IDLE and REQ: IDLE->REQ when eligible; REQ->IDLE on i_cpu_ack; REQ->IDLE on loss of eligibility (withdrawal, no vector issued).
REQ-023 SHALL drive o_cpu_irq = 1 exactly while in REQ.
REQ-024 SHALL, on i_cpu_ack in REQ: load o_vector = table[p] (p sampled that cycle), set in_service[p], clear pending[p], pulse o_vector_vld on the next cycle.
REQ-025 SHALL, on i_cpu_ack in IDLE: load o_vector = default vector, pulse o_vector_vld and o_spurious, change no other state.
REQ-026 SHALL, on i_cpu_eoi: clear in_service[c]; with in_service = 0, pulse o_spurious only.
REQ-027 SHALL keep pending[p] set when a new strobe for p coincides with its ack (re-request wins over the clear).
REQ-028 SHALL use the pre-write table value when i_wr_en and i_cpu_ack target the same entry in the same cycle.
REQ-029 SHALL process ack and EOI in the same cycle with EOI applied to in_service before ack sets its bit.
REQ-030 SHALL drive o_busy = |in_service, registered.

Reset
REQ-031 SHALL clear pending, in_service, o_cpu_irq, o_vector, o_vector_vld, o_busy, o_spurious and set FSM = IDLE on i_rst low, asynchronously.
REQ-032 SHALL reset all vector table entries, including the default vector, to 0.
REQ-033 SHALL discard any in-flight request when reset asserts mid-REQ; no vector pulse after release.

Structure
REQ-034 SHALL place NUM_IRQ, IDX_W (5), VEC_W and the FSM state encoding in shared package vic_pkg.
REQ-035 SHALL instantiate sub-module vic_prio_enc (lowest-set-bit encoder with valid output) twice, for p and c.

Verification
REQ-036 SHALL cover: strobe idx 7, table[7]=0x1000_0070, ack -> o_vector=0x1000_0070, o_vector_vld one cycle, o_busy=1, o_cpu_irq low.
REQ-037 SHALL cover: idx 7 in service, strobe idx 3 -> o_cpu_irq re-asserts; strobe idx 9 instead -> o_cpu_irq stays low until EOI.
REQ-038 SHALL cover: strobes idx 3 and 9, ack, EOI, ack -> vectors table[3] then table[9]; two EOIs -> o_busy=0.
REQ-039 SHALL cover: ack with no request -> default vector 0xFFFF_0000 output, o_spurious=1; EOI with none in service -> o_spurious=1.
REQ-040 SHALL cover: i_en dropped in REQ -> o_cpu_irq low next cycle, pending kept; i_rst low in REQ -> all outputs 0.
